// File: rtl/instr_reg_ctrl.sv
// In-order queue controller for the instruction register: round-robin write arbitration,
// sequential read-out through a registered valid/ready stage, IR reset sequencing and drain.
// Optional: define IR_CTRL_STATS_EN to build the saturating per-requester grant counters.
module instr_reg_ctrl #(
   parameter int DEPTH = 32,
   parameter int PTR_W = 5,
   parameter int OPC_W = 4,
   parameter int OP_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [OPC_W-1:0]          req0_opcode,
   input  logic [OP_W-1:0]           req0_op_a,
   input  logic [OP_W-1:0]           req0_op_b,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [OPC_W-1:0]          req1_opcode,
   input  logic [OP_W-1:0]           req1_op_a,
   input  logic [OP_W-1:0]           req1_op_b,
   output logic                      ir_reset_n,
   output logic                      ir_load_en,
   output logic [PTR_W-1:0]          ir_write_pointer,
   output logic [OPC_W-1:0]          ir_opcode,
   output logic [OP_W-1:0]           ir_operand_a,
   output logic [OP_W-1:0]           ir_operand_b,
   output logic [PTR_W-1:0]          ir_read_pointer,
   input  logic [OPC_W+2*OP_W-1:0]   ir_instruction_word,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OPC_W-1:0]          out_opcode,
   output logic [OP_W-1:0]           out_op_a,
   output logic [OP_W-1:0]           out_op_b,
   input  logic                      drain_req,
   output logic                      drain_done,
   output logic [PTR_W:0]            count,
   output logic                      full,
   output logic                      empty,
   output logic [15:0]               req0_grants,
   output logic [15:0]               req1_grants
);

   localparam int IW = OPC_W + 2*OP_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

   state_t           state;
   logic             init_cnt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   cnt;
   logic             prio;       // 0: req0 wins a tie, 1: req1 wins a tie
   logic             accepting;
   logic             grant0;
   logic             grant1;
   logic             grant;
   logic             pop;

   always_comb begin
      accepting = (state == RUN) && (cnt != FULL_CNT);
      grant0    = accepting && req0_valid && (!req1_valid || !prio);
      grant1    = accepting && req1_valid && (!req0_valid ||  prio);
      grant     = grant0 || grant1;
      pop       = (state != INIT) && (cnt != '0) && (!out_valid || out_ready);
   end

   always_comb begin
      ir_opcode    = req0_opcode;
      ir_operand_a = req0_op_a;
      ir_operand_b = req0_op_b;
      if (grant1) begin
         ir_opcode    = req1_opcode;
         ir_operand_a = req1_op_a;
         ir_operand_b = req1_op_b;
      end
   end

   assign req0_ready       = grant0;
   assign req1_ready       = grant1;
   assign ir_load_en       = grant;
   assign ir_write_pointer = wr_ptr;
   assign ir_read_pointer  = rd_ptr;
   assign count            = cnt;
   assign full             = (cnt == FULL_CNT);
   assign empty            = (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         init_cnt   <= 1'b0;
         ir_reset_n <= 1'b0;
         drain_done <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         prio       <= 1'b0;
         out_valid  <= 1'b0;
         out_opcode <= '0;
         out_op_a   <= '0;
         out_op_b   <= '0;
      end else begin
         drain_done <= 1'b0;
         case (state)
            INIT: begin
               // hold the IR in reset for two cycles before accepting anything
               init_cnt <= 1'b1;
               if (init_cnt) begin
                  state      <= RUN;
                  ir_reset_n <= 1'b1;
               end
            end
            RUN: begin
               if (drain_req) state <= DRAIN;
            end
            DRAIN: begin
               if (cnt == '0 && !out_valid) begin
                  state      <= RUN;
                  drain_done <= 1'b1;
               end
            end
            default: state <= INIT;
         endcase

         if (grant) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            prio   <= grant0;
         end

         if (pop) begin
            out_valid  <= 1'b1;
            out_opcode <= ir_instruction_word[IW-1 -: OPC_W];
            out_op_a   <= ir_instruction_word[2*OP_W-1 -: OP_W];
            out_op_b   <= ir_instruction_word[OP_W-1:0];
            rd_ptr     <= rd_ptr + PTR_W'(1);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case ({grant, pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef IR_CTRL_STATS_EN
   logic [15:0] g0_cnt;
   logic [15:0] g1_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         g0_cnt <= '0;
         g1_cnt <= '0;
      end else begin
         if (grant0 && g0_cnt != 16'hFFFF) g0_cnt <= g0_cnt + 16'd1;
         if (grant1 && g1_cnt != 16'hFFFF) g1_cnt <= g1_cnt + 16'd1;
      end
   end

   assign req0_grants = g0_cnt;
   assign req1_grants = g1_cnt;
`else
   assign req0_grants = '0;
   assign req1_grants = '0;
`endif

endmodule
